// File: rtl/core_mem_lsu.sv
// MEM-stage load/store unit: issues one data-memory access per memory op, aligns/extends load data.
// Latency: 1 cycle for ALU results, >=2 for stores, >=3 for loads; stalls upstream while busy.
module core_mem_lsu #(
   parameter int ADDR_W = 64
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [63:0]       ex_out,
   input  logic [63:0]       ex_B_data,
   input  logic [4:0]        ex_W_regnum,
   input  logic              ex_write_enable,
   input  logic [1:0]        ex_mem_load_type,
   input  logic [1:0]        ex_mem_store_type,
   input  logic              ex_signed_byte,
   input  logic              ex_signed_word,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic              mem_req_we,
   output logic [7:0]        mem_req_be,
   output logic [63:0]       mem_req_wdata,
   input  logic              mem_resp_valid,
   input  logic [63:0]       mem_resp_rdata,
   output logic              stall_out,
   output logic              addr_error,
   output logic [63:0]       MEM_data,
   output logic [4:0]        MEM_W_regnum,
   output logic              MEM_write_enable
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

   state_t            r_state;
   logic              r_done;
   logic [ADDR_W-1:0] r_addr;
   logic [2:0]        r_off;
   logic [1:0]        r_size;
   logic              r_is_load;
   logic              r_sb;
   logic              r_sw;
   logic              r_we;
   logic [4:0]        r_rd;
   logic [7:0]        r_be;
   logic [63:0]       r_wdata;
   logic              r_addr_err;
   logic [63:0]       r_mem_data;
   logic [4:0]        r_mem_rd;
   logic              r_mem_we;

   logic              w_is_load;
   logic              w_mem_op;
   logic [1:0]        w_size;
   logic [2:0]        w_off;
   logic              w_misalign;
   logic              w_issue;
   logic [7:0]        w_be;
   logic [63:0]       w_wdata;
   logic [63:0]       w_shifted;
   logic [63:0]       w_load_val;

   assign w_is_load  = (ex_mem_load_type != 2'd0);
   assign w_mem_op   = w_is_load | (ex_mem_store_type != 2'd0);
   assign w_size     = w_is_load ? ex_mem_load_type : ex_mem_store_type;
   assign w_off      = ex_out[2:0];
   assign w_misalign = ((w_size == 2'd2) && (w_off[1:0] != 2'd0)) ||
                       ((w_size == 2'd3) && (w_off != 3'd0));
   // r_done marks the one cycle where EX still holds the op that just completed
   assign w_issue    = (r_state == S_IDLE) && !r_done && w_mem_op && !w_misalign;
   assign stall_out  = (r_state != S_IDLE) | w_issue;
   assign w_wdata    = ex_B_data << {w_off, 3'b000};

   always_comb begin
      w_be = 8'hFF;
      case (w_size)
         2'd1:    w_be = 8'b0000_0001 << w_off;
         2'd2:    w_be = 8'b0000_1111 << w_off;
         default: w_be = 8'hFF;
      endcase
   end

   assign w_shifted = mem_resp_rdata >> {r_off, 3'b000};

   always_comb begin
      w_load_val = w_shifted;
      case (r_size)
         2'd1:    w_load_val = {{56{r_sb & w_shifted[7]}}, w_shifted[7:0]};
         2'd2:    w_load_val = {{32{r_sw & w_shifted[31]}}, w_shifted[31:0]};
         default: w_load_val = w_shifted;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_done     <= 1'b0;
         r_addr     <= '0;
         r_off      <= 3'd0;
         r_size     <= 2'd0;
         r_is_load  <= 1'b0;
         r_sb       <= 1'b0;
         r_sw       <= 1'b0;
         r_we       <= 1'b0;
         r_rd       <= 5'd0;
         r_be       <= 8'd0;
         r_wdata    <= 64'd0;
         r_addr_err <= 1'b0;
         r_mem_data <= 64'd0;
         r_mem_rd   <= 5'd0;
         r_mem_we   <= 1'b0;
      end else begin
         r_addr_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (r_done) begin
                  r_done <= 1'b0;
               end else if (w_mem_op && w_misalign) begin
                  r_addr_err <= 1'b1;
                  r_mem_we   <= 1'b0;
               end else if (w_mem_op) begin
                  r_addr    <= {ex_out[ADDR_W-1:3], 3'b000};
                  r_off     <= w_off;
                  r_size    <= w_size;
                  r_is_load <= w_is_load;
                  r_sb      <= ex_signed_byte;
                  r_sw      <= ex_signed_word;
                  r_we      <= ex_write_enable;
                  r_rd      <= ex_W_regnum;
                  r_be      <= w_be;
                  r_wdata   <= w_wdata;
                  r_mem_we  <= 1'b0;
                  r_state   <= S_REQ;
               end else begin
                  r_mem_data <= ex_out;
                  r_mem_rd   <= ex_W_regnum;
                  r_mem_we   <= ex_write_enable;
               end
            end
            S_REQ: begin
               if (mem_req_ready) begin
                  if (r_is_load) begin
                     r_state <= S_WAIT;
                  end else begin
                     r_mem_we <= 1'b0;
                     r_done   <= 1'b1;
                     r_state  <= S_IDLE;
                  end
               end
            end
            S_WAIT: begin
               if (mem_resp_valid) begin
                  r_mem_data <= w_load_val;
                  r_mem_rd   <= r_rd;
                  r_mem_we   <= r_we;
                  r_done     <= 1'b1;
                  r_state    <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign mem_req_valid    = (r_state == S_REQ);
   assign mem_req_addr     = r_addr;
   assign mem_req_we       = ~r_is_load;
   assign mem_req_be       = r_be;
   assign mem_req_wdata    = r_wdata;
   assign addr_error       = r_addr_err;
   assign MEM_data         = r_mem_data;
   assign MEM_W_regnum     = r_mem_rd;
   assign MEM_write_enable = r_mem_we;

endmodule

// File: tb/tb_core_mem_lsu.sv
// Directed bench for core_mem_lsu: vector table for single-cycle ops, hand sequences for memory ops.
module tb_core_mem_lsu;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [63:0] ex_out = '0;
   logic [63:0] ex_B_data = '0;
   logic [4:0]  ex_W_regnum = '0;
   logic        ex_write_enable = 1'b0;
   logic [1:0]  ex_mem_load_type = '0;
   logic [1:0]  ex_mem_store_type = '0;
   logic        ex_signed_byte = 1'b0;
   logic        ex_signed_word = 1'b0;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b0;
   logic [63:0] mem_req_addr;
   logic        mem_req_we;
   logic [7:0]  mem_req_be;
   logic [63:0] mem_req_wdata;
   logic        mem_resp_valid = 1'b0;
   logic [63:0] mem_resp_rdata = '0;
   logic        stall_out;
   logic        addr_error;
   logic [63:0] MEM_data;
   logic [4:0]  MEM_W_regnum;
   logic        MEM_write_enable;

   int n_chk  = 0;
   int n_pass = 0;

   core_mem_lsu #(.ADDR_W(64)) dut (
      .clock(clock), .reset(reset),
      .ex_out(ex_out), .ex_B_data(ex_B_data), .ex_W_regnum(ex_W_regnum),
      .ex_write_enable(ex_write_enable), .ex_mem_load_type(ex_mem_load_type),
      .ex_mem_store_type(ex_mem_store_type), .ex_signed_byte(ex_signed_byte),
      .ex_signed_word(ex_signed_word),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we), .mem_req_be(mem_req_be),
      .mem_req_wdata(mem_req_wdata), .mem_resp_valid(mem_resp_valid),
      .mem_resp_rdata(mem_resp_rdata), .stall_out(stall_out), .addr_error(addr_error),
      .MEM_data(MEM_data), .MEM_W_regnum(MEM_W_regnum), .MEM_write_enable(MEM_write_enable)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [63:0] out;
      logic [4:0]  rd;
      logic        we;
      logic [1:0]  lt;
      logic [1:0]  st;
      logic        e_stall;
      logic [63:0] e_data;
      logic [4:0]  e_rd;
      logic        e_we;
      logic        e_err;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic set_ex(input logic [63:0] out, input logic [63:0] b, input logic [4:0] rd,
                         input logic we, input logic [1:0] lt, input logic [1:0] st,
                         input logic sb, input logic sw);
      ex_out = out; ex_B_data = b; ex_W_regnum = rd; ex_write_enable = we;
      ex_mem_load_type = lt; ex_mem_store_type = st; ex_signed_byte = sb; ex_signed_word = sw;
   endtask

   // Plays the memory side until stall drops; returns at the negedge of the first unstalled cycle.
   task automatic run_mem(input logic is_load, input int low, input logic [63:0] rdata,
                          output int stalls, output int valids, output logic [63:0] addr,
                          output logic [63:0] wdata, output logic [7:0] be, output logic we);
      logic acc;
      logic done;
      acc = 1'b0; done = 1'b0; stalls = 0; valids = 0;
      addr = '0; wdata = '0; be = '0; we = 1'b0;
      for (int c = 0; c < 60 && !done; c++) begin
         mem_req_ready  = (valids >= low);
         mem_resp_valid = acc & is_load;
         mem_resp_rdata = rdata;
         @(negedge clock);
         if (!stall_out) begin
            done = 1'b1;
         end else begin
            stalls++;
            acc = 1'b0;
            if (mem_req_valid) begin
               valids++;
               addr = mem_req_addr; wdata = mem_req_wdata; be = mem_req_be; we = mem_req_we;
               acc = mem_req_ready;
            end
            @(posedge clock); #1;
         end
      end
      mem_resp_valid = 1'b0;
      chk("stall_bounded", {63'd0, done}, 64'd1);
   endtask

   initial begin
      int          stalls, valids;
      logic [63:0] a, wd;
      logic [7:0]  be;
      logic        we;

      //           out                      rd  we lt st  stall data                    rd  we err
      vecs[0] = '{64'h1234,                 5,  1, 0, 0,  0, 64'h1234,                 5,  1, 0};
      vecs[1] = '{64'hFFFF_0000_AAAA_5555,  31, 1, 0, 0,  0, 64'hFFFF_0000_AAAA_5555,  31, 1, 0};
      vecs[2] = '{64'h3002,                 7,  1, 3, 0,  0, 64'hFFFF_0000_AAAA_5555,  31, 0, 1};
      vecs[3] = '{64'h2002,                 3,  0, 0, 2,  0, 64'hFFFF_0000_AAAA_5555,  31, 0, 1};
      vecs[4] = '{64'h1001,                 4,  1, 2, 0,  0, 64'hFFFF_0000_AAAA_5555,  31, 0, 1};
      vecs[5] = '{64'h0,                    0,  1, 0, 0,  0, 64'h0,                    0,  1, 0};

      // Reset state
      set_ex(64'h55, 64'h0, 5'd9, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0);
      reset = 1'b0;
      @(posedge clock); #1;
      @(posedge clock); #1;
      chk("rst_data", MEM_data, 64'd0);
      chk("rst_rd", {59'd0, MEM_W_regnum}, 64'd0);
      chk("rst_we", {63'd0, MEM_write_enable}, 64'd0);
      chk("rst_err", {63'd0, addr_error}, 64'd0);
      chk("rst_valid", {63'd0, mem_req_valid}, 64'd0);
      reset = 1'b1;

      mem_req_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         set_ex(vecs[i].out, 64'h0, vecs[i].rd, vecs[i].we, vecs[i].lt, vecs[i].st, 1'b0, 1'b0);
         @(negedge clock);
         chk($sformatf("v%0d_stall", i), {63'd0, stall_out}, {63'd0, vecs[i].e_stall});
         chk($sformatf("v%0d_valid", i), {63'd0, mem_req_valid}, 64'd0);
         @(posedge clock); #1;
         chk($sformatf("v%0d_data", i), MEM_data, vecs[i].e_data);
         chk($sformatf("v%0d_rd", i), {59'd0, MEM_W_regnum}, {59'd0, vecs[i].e_rd});
         chk($sformatf("v%0d_we", i), {63'd0, MEM_write_enable}, {63'd0, vecs[i].e_we});
         chk($sformatf("v%0d_err", i), {63'd0, addr_error}, {63'd0, vecs[i].e_err});
      end

      // Signed byte load
      set_ex(64'h1003, 64'h0, 5'd9, 1'b1, 2'd1, 2'd0, 1'b1, 1'b0);
      run_mem(1'b1, 0, 64'h0000_0000_8000_0000, stalls, valids, a, wd, be, we);
      chk("lb_stalls", 64'(stalls), 64'd3);
      chk("lb_valids", 64'(valids), 64'd1);
      chk("lb_addr", a, 64'h1000);
      chk("lb_be", {56'd0, be}, 64'h08);
      chk("lb_we", {63'd0, we}, 64'd0);
      chk("lb_data", MEM_data, 64'hFFFF_FFFF_FFFF_FF80);
      chk("lb_rd", {59'd0, MEM_W_regnum}, 64'd9);
      chk("lb_wen", {63'd0, MEM_write_enable}, 64'd1);
      @(posedge clock); #1;

      // Word store with two cycles of backpressure
      set_ex(64'h2004, 64'hDEAD_BEEF, 5'd2, 1'b0, 2'd0, 2'd2, 1'b0, 1'b0);
      run_mem(1'b0, 2, 64'h0, stalls, valids, a, wd, be, we);
      chk("sw_stalls", 64'(stalls), 64'd4);
      chk("sw_valids", 64'(valids), 64'd3);
      chk("sw_addr", a, 64'h2000);
      chk("sw_be", {56'd0, be}, 64'hF0);
      chk("sw_wdata", wd, 64'hDEAD_BEEF_0000_0000);
      chk("sw_we", {63'd0, we}, 64'd1);
      chk("sw_wen", {63'd0, MEM_write_enable}, 64'd0);
      @(posedge clock); #1;

      // Unsigned word load, upper lane
      set_ex(64'h4004, 64'h0, 5'd12, 1'b1, 2'd2, 2'd0, 1'b0, 1'b0);
      run_mem(1'b1, 0, 64'h8765_4321_0000_0000, stalls, valids, a, wd, be, we);
      chk("lw_be", {56'd0, be}, 64'hF0);
      chk("lw_data", MEM_data, 64'h0000_0000_8765_4321);
      chk("lw_rd", {59'd0, MEM_W_regnum}, 64'd12);
      @(posedge clock); #1;

      // Signed word load, same data
      set_ex(64'h4004, 64'h0, 5'd13, 1'b1, 2'd2, 2'd0, 1'b0, 1'b1);
      run_mem(1'b1, 0, 64'h8765_4321_0000_0000, stalls, valids, a, wd, be, we);
      chk("lws_data", MEM_data, 64'hFFFF_FFFF_8765_4321);
      @(posedge clock); #1;

      // Unsigned byte load from lane 6 with a late response path
      set_ex(64'h1006, 64'h0, 5'd14, 1'b1, 2'd1, 2'd0, 1'b0, 1'b0);
      run_mem(1'b1, 1, 64'h00AB_0000_0000_0000, stalls, valids, a, wd, be, we);
      chk("lbu_stalls", 64'(stalls), 64'd4);
      chk("lbu_be", {56'd0, be}, 64'h40);
      chk("lbu_data", MEM_data, 64'h0000_0000_0000_00AB);
      @(posedge clock); #1;

      // Doubleword load
      set_ex(64'h5000, 64'h0, 5'd15, 1'b1, 2'd3, 2'd0, 1'b1, 1'b1);
      run_mem(1'b1, 0, 64'h0123_4567_89AB_CDEF, stalls, valids, a, wd, be, we);
      chk("ld_be", {56'd0, be}, 64'hFF);
      chk("ld_data", MEM_data, 64'h0123_4567_89AB_CDEF);
      @(posedge clock); #1;

      // Reset while waiting for a load response; the late response must be dropped
      mem_req_ready = 1'b1;
      set_ex(64'h6000, 64'h0, 5'd3, 1'b1, 2'd3, 2'd0, 1'b0, 1'b0);
      @(posedge clock); #1;
      @(posedge clock); #1;
      chk("rw_stall_before", {63'd0, stall_out}, 64'd1);
      reset = 1'b0;
      set_ex(64'h0, 64'h0, 5'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
      @(posedge clock); #1;
      reset = 1'b1;
      mem_resp_valid = 1'b1;
      mem_resp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      @(negedge clock);
      chk("rw_stall", {63'd0, stall_out}, 64'd0);
      chk("rw_valid", {63'd0, mem_req_valid}, 64'd0);
      chk("rw_data", MEM_data, 64'd0);
      chk("rw_wen", {63'd0, MEM_write_enable}, 64'd0);
      @(posedge clock); #1;
      mem_resp_valid = 1'b0;
      chk("rw_data_after", MEM_data, 64'd0);
      chk("rw_stall_after", {63'd0, stall_out}, 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/core_mem_lsu.md
# core_MEM_lsu

Memory-stage load/store unit consuming the EX stage pipeline register. Issues data-memory requests over a valid/ready bus, stalls the pipeline while an access is outstanding, aligns and sign/zero-extends load data, and drives the MEM/WB register. That register is also `MEM_data`, the forwarding value fed back to EX.

## Interface
Parameters:
- `ADDR_W`, 64, address width taken from EX `out`.

Ports:
- `clock`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-low reset; sampled on posedge `clock`.
- `ex_out`  in  64  EX result; byte address for memory ops, writeback value otherwise.
- `ex_B_data`  in  64  store data, right-aligned.
- `ex_W_regnum`  in  5  destination register.
- `ex_write_enable`  in  1  register write request.
- `ex_mem_load_type`  in  2  load size: 0 none, 1 byte, 2 word (32 b), 3 doubleword.
- `ex_mem_store_type`  in  2  store size, same encoding.
- `ex_signed_byte`, `ex_signed_word`  in  1 each  sign-extend byte/word loads.
- `mem_req_valid`  out  1  request valid.
- `mem_req_ready`  in  1  request accepted when valid&ready.
- `mem_req_addr`  out  ADDR_W  doubleword-aligned address (`ex_out` with [2:0] = 0).
- `mem_req_we`  out  1  1 = store.
- `mem_req_be`  out  8  byte enables.
- `mem_req_wdata`  out  64  store data shifted into lane.
- `mem_resp_valid`  in  1  load data valid.
- `mem_resp_rdata`  in  64  load doubleword.
- `stall_out`  out  1  freeze IF/ID/EX.
- `addr_error`  out  1  registered misaligned-access flag, one cycle.
- `MEM_data`  out  64  registered writeback/forward value.
- `MEM_W_regnum`  out  5  registered destination.
- `MEM_write_enable`  out  1  registered write enable.

## Operation
- FSM states: IDLE, REQ, WAIT.
- IDLE, no memory op (both types 0): pass through. `MEM_data`←`ex_out`, regnum/write_enable copied next edge. No stall.
- IDLE, memory op: combinational `stall_out`=1. Latch address, size, signedness, data, regnum, and we. Go to REQ.
- Misaligned op: byte offset `ex_out[2:0]` not a multiple of size (word needs [1:0]=0; dword needs [2:0]=0). No request is issued. Next edge: `addr_error`=1, `MEM_write_enable`=0, stay IDLE.
- REQ: `mem_req_valid`=1 with stable addr/we/be/wdata until accepted.
  - Store accept: `MEM_write_enable`=0, go IDLE.
  - Load accept: go WAIT.
- WAIT: on `mem_resp_valid`, select bytes at offset, then extend.
  - Byte: sign-extend if `signed_byte`, else zero-extend.
  - Word: sign-extend if `signed_word`, else zero-extend.
  - Dword: no extension.
  - Write `MEM_data`, regnum, and latched write_enable. Go IDLE.
- Byte enables: byte 8'b1<<off; word 8'b1111<<off; dword 8'hFF. `wdata` = `B_data` << (8·off).
- `mem_resp_valid` outside WAIT is ignored.
- `stall_out` = (state≠IDLE) | (IDLE & memory op present & aligned). It deasserts in the cycle the FSM returns to IDLE.

## Timing
- Reset (reset=0 at posedge): state IDLE. `MEM_data`=0, `MEM_W_regnum`=0, `MEM_write_enable`=0, `addr_error`=0, `mem_req_valid`=0. Applies mid-transaction: the pending request is abandoned and a later response is ignored.
- Non-memory op: 1-cycle latency, no stall.
- Store, ready always 1: op seen cycle N (stall). Cycle N+1 is REQ, accepted, stall=1. IDLE at N+2. Stall lasts 2 cycles.
- Load, ready=1, response 1 cycle after accept: N IDLE, N+1 REQ, N+2 WAIT with resp. `MEM_data` valid at N+3, stall cycles N..N+2.
- Each cycle of `mem_req_ready`=0 or a missing response adds one stall cycle. No timeout.
- While stalled, EX inputs are held by upstream; the block ignores them outside IDLE.

## Test plan
- Add passthrough: `ex_out`=64'h1234, we=1, rd=5, no mem op → next cycle `MEM_data`=64'h1234, rd=5, we=1, no stall.
- Signed byte load: addr 64'h1003, signed_byte=1, rdata=64'h00000000_80000000 → be 8'h08, addr 64'h1000, `MEM_data`=64'hFFFF_FFFF_FFFF_FF80. Stall 3 cycles.
- Word store: addr 64'h2004, B_data=64'hDEADBEEF, ready low 2 cycles → valid held 3 cycles, be 8'hF0, wdata 64'hDEADBEEF_00000000, stall 4 cycles, `MEM_write_enable`=0.
- Misaligned dword load: addr 64'h3002 → no `mem_req_valid`, `addr_error`=1 for one cycle, no write.
- Unsigned word load: addr 64'h4004, signed_word=0, rdata=64'h87654321_00000000 → `MEM_data`=64'h0000_0000_8765_4321.
- Reset in WAIT: reset=0 one cycle, then a response arrives → state IDLE, outputs 0, response ignored, stall=0.
